// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data requesters,
// data first with a fetch anti-starvation streak limit and a response timeout. Rev 1.0
`default_nettype none

module mem_arbiter #(
  parameter int AWIDTH_M   = 32,
  parameter int DWIDTH_M   = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                ma_clk,
  input  logic                ma_rst,
  input  logic                ma_i_if_req,
  input  logic [AWIDTH_M-1:0] ma_i_if_addr,
  output logic                ma_o_if_valid,
  output logic [DWIDTH_M-1:0] ma_o_if_instr,
  input  logic                ma_i_d_req,
  input  logic                ma_i_d_we,
  input  logic [3:0]          ma_i_d_mask,
  input  logic [AWIDTH_M-1:0] ma_i_d_addr,
  input  logic [DWIDTH_M-1:0] ma_i_d_wdata,
  output logic                ma_o_d_valid,
  output logic [DWIDTH_M-1:0] ma_o_d_rdata,
  output logic                ma_o_m_req,
  output logic                ma_o_m_we,
  output logic [3:0]          ma_o_m_mask,
  output logic [AWIDTH_M-1:0] ma_o_m_addr,
  output logic [DWIDTH_M-1:0] ma_o_m_wdata,
  input  logic                ma_i_m_ack,
  input  logic [DWIDTH_M-1:0] ma_i_m_rdata,
  output logic                ma_o_stall_if,
  output logic                ma_o_stall_mem,
  output logic                ma_o_err
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic       grant_d, grant_if, done, abort;

  always_ff @(posedge ma_clk or negedge ma_rst) begin
    if (!ma_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (ma_i_d_req && (!ma_i_if_req || streak < STREAK_MAX)) begin
          grant_d  = 1'b1;
          state_nx = D_BUSY;
        end else if (ma_i_if_req) begin
          grant_if = 1'b1;
          state_nx = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        // ack beats a coinciding timeout
        if (ma_i_m_ack) begin
          done     = 1'b1;
          state_nx = RESP;
        end else if (tcnt == TCNT_LAST) begin
          abort    = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ma_clk or negedge ma_rst) begin
    if (!ma_rst) begin
      streak        <= '0;
      tcnt          <= '0;
      ma_o_m_req    <= 1'b0;
      ma_o_m_we     <= 1'b0;
      ma_o_m_mask   <= '0;
      ma_o_m_addr   <= '0;
      ma_o_m_wdata  <= '0;
      ma_o_if_valid <= 1'b0;
      ma_o_if_instr <= '0;
      ma_o_d_valid  <= 1'b0;
      ma_o_d_rdata  <= '0;
      ma_o_err      <= 1'b0;
    end else begin
      ma_o_if_valid <= 1'b0;
      ma_o_d_valid  <= 1'b0;
      ma_o_err      <= 1'b0;
      if (state == IDLE) begin
        if (!ma_i_if_req || grant_if) streak <= '0;
        else if (grant_d)             streak <= streak + 4'd1;
      end
      if (grant_d) begin
        ma_o_m_req   <= 1'b1;
        ma_o_m_we    <= ma_i_d_we;
        ma_o_m_mask  <= ma_i_d_mask;
        ma_o_m_addr  <= ma_i_d_addr;
        ma_o_m_wdata <= ma_i_d_wdata;
        tcnt         <= '0;
      end else if (grant_if) begin
        ma_o_m_req   <= 1'b1;
        ma_o_m_we    <= 1'b0;
        ma_o_m_mask  <= 4'hF;
        ma_o_m_addr  <= ma_i_if_addr;
        ma_o_m_wdata <= '0;
        tcnt         <= '0;
      end
      if (done || abort) begin
        ma_o_m_req <= 1'b0;
        ma_o_err   <= abort;
        if (state == IF_BUSY) begin
          ma_o_if_valid <= 1'b1;
          ma_o_if_instr <= done ? ma_i_m_rdata : '0;
        end else begin
          ma_o_d_valid <= 1'b1;
          ma_o_d_rdata <= (done && !ma_o_m_we) ? ma_i_m_rdata : '0;
        end
      end else if (state == IF_BUSY || state == D_BUSY) begin
        tcnt <= tcnt + 8'd1;
      end
    end
  end

  assign ma_o_stall_if  = ma_i_if_req & ~ma_o_if_valid;
  assign ma_o_stall_mem = ma_i_d_req & ~ma_o_d_valid;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the fetch stage (instruction requester) and the memory stage (data load/store requester) of the 5-stage pipeline.
- Data requests have priority. A streak limit keeps fetch from starving.
- Produces stall levels that the pipeline registers use as hold enables.
- A response timeout aborts hung memory accesses and flags an error.

Parameters:
- AWIDTH_M, 32, byte address width on all ports.
- DWIDTH_M, 32, data/instruction width.
- MAX_STREAK, 4, consecutive data grants allowed while a fetch is waiting before fetch is forced; legal range 1..15.
- TIMEOUT, 64, cycles in a busy state without ack before abort; legal range 2..255.

Ports:
- ma_clk  in  1  clock; all state updates on the rising edge.
- ma_rst  in  1  asynchronous, active-low reset.
- ma_i_if_req  in  1  fetch request, level; held until ma_o_if_valid.
- ma_i_if_addr  in  AWIDTH_M  fetch address.
- ma_o_if_valid  out  1  one-cycle response pulse to fetch.
- ma_o_if_instr  out  DWIDTH_M  fetched instruction; valid with ma_o_if_valid.
- ma_i_d_req  in  1  data request, level; held until ma_o_d_valid.
- ma_i_d_we  in  1  1 = store, 0 = load.
- ma_i_d_mask  in  4  byte-enable mask for stores.
- ma_i_d_addr  in  AWIDTH_M  data address.
- ma_i_d_wdata  in  DWIDTH_M  store data.
- ma_o_d_valid  out  1  one-cycle response pulse to data.
- ma_o_d_rdata  out  DWIDTH_M  load data; 0 for stores.
- ma_o_m_req  out  1  memory request, held until ack.
- ma_o_m_we  out  1  memory write enable.
- ma_o_m_mask  out  4  memory byte mask; 4'b1111 for fetches.
- ma_o_m_addr  out  AWIDTH_M  memory address.
- ma_o_m_wdata  out  DWIDTH_M  memory write data.
- ma_i_m_ack  in  1  memory completion, one-cycle pulse.
- ma_i_m_rdata  in  DWIDTH_M  memory read data, valid with ack.
- ma_o_stall_if  out  1  combinational: ma_i_if_req & ~ma_o_if_valid.
- ma_o_stall_mem  out  1  combinational: ma_i_d_req & ~ma_o_d_valid.
- ma_o_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - State returns to IDLE.
  - All registered outputs go to 0, including ma_o_m_req, which drops immediately, even mid-access.
  - Streak counter and timeout counter are cleared.
  - No response is issued for an access in flight.
- FSM states: IDLE, IF_BUSY, D_BUSY, RESP.
- IDLE arbitration, evaluated at each edge:
  - d_req only -> D_BUSY.
  - if_req only -> IF_BUSY.
  - Both requesting and streak < MAX_STREAK -> D_BUSY, streak + 1.
  - Both requesting and streak == MAX_STREAK -> IF_BUSY, streak cleared.
  - Streak is also cleared at any IDLE edge where if_req = 0.
  - Streak is not changed when only d_req is requesting while if_req = 0 (it is cleared as above).
- Entering a busy state:
  - ma_o_m_req <= 1.
  - Address, we, mask and wdata are latched from the granted requester.
  - Fetch grants drive we = 0 and mask = 4'b1111.
  - The timeout counter is cleared.
- Busy state, at each edge:
  - If ma_i_m_ack: capture ma_i_m_rdata into the granted requester's response register (a store writes 0), set that requester's valid, clear ma_o_m_req, go to RESP.
  - Else if the timeout counter == TIMEOUT-1: abort. Clear ma_o_m_req, response data = 0, set valid and ma_o_err, go to RESP.
  - Else: increment the timeout counter.
  - Ack and timeout on the same edge: ack wins, no error.
- RESP:
  - Exactly one cycle; the valid (and ma_o_err if aborting) pulse is high here.
  - Requests are ignored.
  - Next state is IDLE, where valid and err return to 0.
  - The requester drops or changes its request in the RESP cycle.
- Response data registers hold their value until the next response to the same requester.
- Latency: request sampled at edge N -> m_req high after N. Ack sampled at edge N+k (k ≥ 1) -> valid high for the cycle after N+k. The minimum request-to-valid time is 2 cycles. Back-to-back accesses are separated by a 1-cycle IDLE bubble.
- Ack outside a busy state is ignored. Request changes while that requester is being served are ignored because inputs are latched at grant.

Test Plan:
- Reset, then a fetch at 0x0000_0040 with memory acking 1 cycle after m_req and rdata 0x2008_0005 -> m_req=1, m_mask=4'hF, m_we=0. if_valid pulses one cycle with instr 0x2008_0005. stall_if is high until that pulse.
- Fetch and load (0x100) requested in the same cycle, ack latency 2 -> the load is served first (d_valid). An IDLE bubble follows, then the fetch is served. stall_if stays high throughout the data access.
- MAX_STREAK=4, d_req held continuously with if_req pending -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- Store to 0x200, mask 4'b0011, wdata 0xDEAD_BEEF -> m_we=1, m_mask=0011, m_wdata=0xDEAD_BEEF. d_valid pulses with d_rdata=0.
- TIMEOUT=8, ack never asserted -> m_req drops after 8 busy cycles. err and d_valid pulse together with rdata=0, then the FSM is back in IDLE. Second case: ack on exactly the 8th busy cycle -> normal response, err stays 0.
- ma_rst asserted 3 cycles into a busy access -> m_req goes low asynchronously and no valid is issued. After release, a new request completes normally.
